bus_master_port: RTL

BUS_MASTER_PORT -- requirements
Module: bus_master_port

---
 rtl/bus_master_port.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/bus_master_port.sv
// Serial bus master: a start/header phase, an address ack, then a write-data or read-data phase on one shared open line.
// Optional MASTER_RETRY_EN: an address-ack timeout re-issues the header once before aborting.
module bus_master_port #(
    parameter int ADDRESS_WIDTH = 15,
    parameter int DATA_WIDTH    = 8,
    parameter int ACK_TIMEOUT   = 15,
    parameter int RD_TIMEOUT    = 255
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     req,
    input  logic                     wr,
    input  logic [ADDRESS_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    output logic [DATA_WIDTH-1:0]    rdata,
    output logic                     done,
    output logic                     err,
    output logic                     busy,
    output logic                     bus_util,
    output logic                     rd_wrt,
    input  logic                     slave_busy,
    inout  wire                      data_bus_serial
);
    localparam int SW  = (ADDRESS_WIDTH > DATA_WIDTH) ? ADDRESS_WIDTH : DATA_WIDTH;
    localparam int CW  = $clog2(SW);
    localparam int ATW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int RTW = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;

    localparam logic [CW-1:0]  HDR_LAST = CW'(ADDRESS_WIDTH - 1);
    localparam logic [CW-1:0]  DAT_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [ATW-1:0] ACK_LAST = ATW'(ACK_TIMEOUT - 1);
    localparam logic [RTW-1:0] RD_LAST  = RTW'(RD_TIMEOUT - 1);

    localparam logic [3:0] S_IDLE   = 4'd0,  S_START0 = 4'd1,  S_START1 = 4'd2,
                           S_HDR    = 4'd3,  S_WAA    = 4'd4,  S_WSYNC0 = 4'd5,
                           S_WSYNC1 = 4'd6,  S_SEND   = 4'd7,  S_WDA    = 4'd8,
                           S_RFREE  = 4'd9,  S_RREADY = 4'd10, S_RX     = 4'd11,
                           S_DONE   = 4'd12, S_ERR    = 4'd13;

    logic [3:0]               state_q, state_d;
    logic [CW-1:0]            bcnt_q, bcnt_d;
    logic [ATW-1:0]           tcnt_q, tcnt_d;
    logic [RTW-1:0]           rcnt_q, rcnt_d;
    logic                     flag_q, flag_d;
    logic [SW-1:0]            sh_q, sh_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic                     wr_q, wr_d;
    logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
`ifdef MASTER_RETRY_EN
    logic                     retry_q, retry_d;
`endif
    logic                     line, rd_now, rd_next, oe, dout;

    assign line = data_bus_serial;

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        tcnt_d  = tcnt_q;
        flag_d  = flag_q;
        sh_d    = sh_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
`ifdef MASTER_RETRY_EN
        retry_d = retry_q;
`endif
        case (state_q)
            S_IDLE: if (req && line && !slave_busy) begin
                addr_d  = addr;
                wdata_d = wdata;
                wr_d    = wr;
                state_d = S_START0;
`ifdef MASTER_RETRY_EN
                retry_d = 1'b0;
`endif
            end
            S_START0: state_d = S_START1;
            S_START1: begin
                sh_d    = SW'(addr_q) << (SW - ADDRESS_WIDTH);
                state_d = S_HDR;
            end
            S_HDR: begin
                sh_d   = sh_q << 1;
                bcnt_d = bcnt_q + 1'b1;
                if (bcnt_q == HDR_LAST) state_d = S_WAA;
            end
            // flag_q remembers that the previous sampled bit was 0
            S_WAA: begin
                tcnt_d = tcnt_q + 1'b1;
                flag_d = !line;
                if (!line && flag_q) state_d = wr_q ? S_WSYNC0 : S_RFREE;
                else if (tcnt_q == ACK_LAST) begin
`ifdef MASTER_RETRY_EN
                    if (!retry_q) begin
                        retry_d = 1'b1;
                        state_d = S_START0;
                    end else state_d = S_ERR;
`else
                    state_d = S_ERR;
`endif
                end
            end
            S_WSYNC0: state_d = S_WSYNC1;
            S_WSYNC1: begin
                sh_d    = SW'(wdata_q) << (SW - DATA_WIDTH);
                state_d = S_SEND;
            end
            S_SEND: begin
                sh_d   = sh_q << 1;
                bcnt_d = bcnt_q + 1'b1;
                if (bcnt_q == DAT_LAST) state_d = S_WDA;
            end
            S_WDA: begin
                tcnt_d = tcnt_q + 1'b1;
                if (!line) flag_d = 1'b1;
                if (line && flag_q) state_d = S_DONE;
                else if (tcnt_q == ACK_LAST) state_d = S_ERR;
            end
            S_RFREE:  if (!slave_busy) state_d = S_RREADY;
            S_RREADY: if (slave_busy) state_d = S_RX;
            // flag_q set once the start bit has been seen
            S_RX: begin
                if (!flag_q) begin
                    if (!line) flag_d = 1'b1;
                end else begin
                    sh_d   = {sh_q[SW-2:0], line};
                    bcnt_d = bcnt_q + 1'b1;
                    if (bcnt_q == DAT_LAST) begin
                        rdata_d = sh_d[DATA_WIDTH-1:0];
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // One budget spans the whole read path, not each read sub-state
        if (rd_now && state_d != S_DONE && rcnt_q == RD_LAST) begin
            state_d = S_ERR;
            rdata_d = rdata_q;
        end

        if (state_d != state_q) begin
            bcnt_d = '0;
            tcnt_d = '0;
            flag_d = 1'b0;
        end
    end

    assign rd_now  = (state_q == S_RFREE) || (state_q == S_RREADY) || (state_q == S_RX);
    assign rd_next = (state_d == S_RFREE) || (state_d == S_RREADY) || (state_d == S_RX);
    assign rcnt_d  = rd_next ? (rd_now ? rcnt_q + 1'b1 : '0) : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            bcnt_q  <= '0;
            tcnt_q  <= '0;
            rcnt_q  <= '0;
            flag_q  <= 1'b0;
            sh_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
`ifdef MASTER_RETRY_EN
            retry_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            tcnt_q  <= tcnt_d;
            rcnt_q  <= rcnt_d;
            flag_q  <= flag_d;
            sh_q    <= sh_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
`ifdef MASTER_RETRY_EN
            retry_q <= retry_d;
`endif
        end
    end

    always_comb begin
        oe   = 1'b0;
        dout = 1'b0;
        case (state_q)
            S_START0, S_START1, S_WSYNC0: oe = 1'b1;
            S_WSYNC1: begin
                oe   = 1'b1;
                dout = 1'b1;
            end
            S_HDR, S_SEND: begin
                oe   = 1'b1;
                dout = sh_q[SW-1];
            end
            default: ;
        endcase
    end

    // Drive depends only on registered state, so reset releases the line at once
    assign data_bus_serial = oe ? dout : 1'bz;

    assign busy     = (state_q != S_IDLE);
    assign bus_util = busy;
    assign rd_wrt   = busy & wr_q;
    assign done     = (state_q == S_DONE);
    assign err      = (state_q == S_ERR);
    assign rdata    = rdata_q;

endmodule
